// File: rtl/rl_pair_scheduler_if.sv
// Bundle of start/stall/force-return inputs and address/strobe/status outputs of rl_pair_scheduler.
// Optional watchdog_err exists only when RL_SCHED_WATCHDOG_EN is defined.
interface rl_pair_scheduler_if #(
  parameter int REF_RAM_ADDR_WIDTH      = 7,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
  parameter int OUTSTANDING_WIDTH       = 6
);
  logic                               start;
  logic                               stall;
  logic                               force_valid_in;
  logic [REF_RAM_ADDR_WIDTH-1:0]      home_rdaddr;
  logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] neighbor_rdaddr;
  logic                               rden;
  logic                               r2_enable;
  logic                               home_last;
  logic                               busy;
  logic                               done;
  logic [1:0]                         state_dbg;
  logic [OUTSTANDING_WIDTH-1:0]       outstanding_dbg;
`ifdef RL_SCHED_WATCHDOG_EN
  logic                               watchdog_err;

  modport master (
    output start, stall, force_valid_in,
    input  home_rdaddr, neighbor_rdaddr, rden, r2_enable, home_last, busy, done,
    input  state_dbg, outstanding_dbg, watchdog_err
  );
  modport slave (
    input  start, stall, force_valid_in,
    output home_rdaddr, neighbor_rdaddr, rden, r2_enable, home_last, busy, done,
    output state_dbg, outstanding_dbg, watchdog_err
  );
`else
  modport master (
    output start, stall, force_valid_in,
    input  home_rdaddr, neighbor_rdaddr, rden, r2_enable, home_last, busy, done,
    input  state_dbg, outstanding_dbg
  );
  modport slave (
    input  start, stall, force_valid_in,
    output home_rdaddr, neighbor_rdaddr, rden, r2_enable, home_last, busy, done,
    output state_dbg, outstanding_dbg
  );
`endif
endinterface

// File: rtl/rl_pair_scheduler.sv
// Pair issue sequencer for one range-limited LJ force tile: home-major address walk, in-flight count, drain and done.
// Optional DRAIN watchdog enabled by defining RL_SCHED_WATCHDOG_EN.
module rl_pair_scheduler #(
  parameter int REF_PARTICLE_NUM        = 100,
  parameter int REF_RAM_ADDR_WIDTH      = 7,
  parameter int NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
  parameter int PIPE_LATENCY            = 31,
  parameter int OUTSTANDING_WIDTH       = 6
) (
  input logic                clk,
  input logic                rst,
  rl_pair_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [REF_RAM_ADDR_WIDTH-1:0] HOME_MAX =
    REF_RAM_ADDR_WIDTH'(REF_PARTICLE_NUM - 1);
  localparam logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] NBR_MAX =
    NEIGHBOR_RAM_ADDR_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);

  if (OUTSTANDING_WIDTH < $clog2(PIPE_LATENCY + 3)) begin : g_width_check
    $error("OUTSTANDING_WIDTH too small to hold PIPE_LATENCY+2");
  end

  state_t                             state_q;
  logic [REF_RAM_ADDR_WIDTH-1:0]      home_q;
  logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nbr_q;
  logic [OUTSTANDING_WIDTH-1:0]       outst_q;
  logic [OUTSTANDING_WIDTH-1:0]       outst_d;
  logic                               r2_enable_q;
  logic                               home_last_q;
  logic                               rden;
  logic                               nbr_wrap;
  logic                               pair_last;
  logic                               fv_take;

  // Handshake: rden is the issue strobe and ~stall is its ready; a pair is
  // transferred (addresses advance, outstanding counts it) on every edge where
  // state is ISSUE and stall is low. force_valid_in is a ready-less pulse.
  assign rden      = (state_q == S_ISSUE) && !bus.stall;
  assign nbr_wrap  = (nbr_q == NBR_MAX);
  assign pair_last = nbr_wrap && (home_q == HOME_MAX);
  assign fv_take   = bus.force_valid_in && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (rden && !fv_take) begin
      outst_d = outst_q + 1'b1;
    end else if (!rden && fv_take) begin
      outst_d = outst_q - 1'b1;
    end
  end

`ifdef RL_SCHED_WATCHDOG_EN
  localparam int WD_WIDTH = $clog2(2 * PIPE_LATENCY + 1);
  // The cycle carrying the last pulse counts as the first cycle of the window,
  // so done lands 2*PIPE_LATENCY cycles after the last received pulse.
  localparam logic [WD_WIDTH-1:0] WD_FIRE = WD_WIDTH'(2 * PIPE_LATENCY - 2);

  logic [WD_WIDTH-1:0] wd_q;
  logic                wd_err_q;
  logic                wd_fire;

  assign wd_fire          = (state_q == S_DRAIN) && !bus.force_valid_in && (wd_q == WD_FIRE);
  assign bus.watchdog_err = wd_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      home_q      <= '0;
      nbr_q       <= '0;
      outst_q     <= '0;
      r2_enable_q <= 1'b0;
      home_last_q <= 1'b0;
`ifdef RL_SCHED_WATCHDOG_EN
      wd_q        <= '0;
      wd_err_q    <= 1'b0;
`endif
    end else begin
      r2_enable_q <= rden;
      home_last_q <= rden && nbr_wrap;
      outst_q     <= outst_d;
`ifdef RL_SCHED_WATCHDOG_EN
      if (state_q == S_DRAIN) begin
        wd_q <= bus.force_valid_in ? '0 : wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_ISSUE;
`ifdef RL_SCHED_WATCHDOG_EN
            wd_err_q <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (rden) begin
            if (nbr_wrap) begin
              nbr_q  <= '0;
              home_q <= pair_last ? '0 : home_q + 1'b1;
            end else begin
              nbr_q <= nbr_q + 1'b1;
            end
            if (pair_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (outst_d == '0) begin
            state_q <= S_DONE;
          end
`ifdef RL_SCHED_WATCHDOG_EN
          else if (wd_fire) begin
            state_q  <= S_DONE;
            wd_err_q <= 1'b1;
            outst_q  <= '0;
          end
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.home_rdaddr     = home_q;
  assign bus.neighbor_rdaddr = nbr_q;
  assign bus.rden            = rden;
  assign bus.r2_enable       = r2_enable_q;
  assign bus.home_last       = home_last_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_DONE);
  assign bus.state_dbg       = state_q;
  assign bus.outstanding_dbg = outst_q;
endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Self-checking bench for rl_pair_scheduler (REF=3, NBR=4, PIPE_LATENCY=5) against a pair-list reference model.
// Watchdog scenario compiled only when RL_SCHED_WATCHDOG_EN is defined.
module tb_rl_pair_scheduler;
  localparam int REF = 3;
  localparam int NBR = 4;
  localparam int PL  = 5;
  localparam int RW  = 2;
  localparam int NW  = 2;
  localparam int OW  = 6;
  localparam int N   = REF * NBR;
  localparam int PW  = RW + NW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rl_pair_scheduler_if #(
    .REF_RAM_ADDR_WIDTH(RW), .NEIGHBOR_RAM_ADDR_WIDTH(NW), .OUTSTANDING_WIDTH(OW)
  ) bus ();

  rl_pair_scheduler #(
    .REF_PARTICLE_NUM(REF), .REF_RAM_ADDR_WIDTH(RW),
    .NEIGHBOR_PARTICLE_NUM(NBR), .NEIGHBOR_RAM_ADDR_WIDTH(NW),
    .PIPE_LATENCY(PL), .OUTSTANDING_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
`ifdef RL_SCHED_WATCHDOG_EN
  bit wd_model = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run from IDLE; returns cycle index of done relative to the start cycle.
  task automatic run_one(input int stall_lo, input int stall_hi, input bit rand_stall,
                         input bit hold_start, input int drop_n, output int run_len);
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] e;
    int  fv_q[$];
    int  issued = 0, retired = 0, r2_n = 0, out_m = 0, t = 0;
    int  done_cyc = -1, done_seen = 0;
    bit  issuing = 0, prev_rden = 0, prev_last = 0, cur_last, cur_fv, cur_stall, exp_rden;
    bit  exp_busy;
    for (int h = 0; h < REF; h++)
      for (int n = 0; n < NBR; n++)
        exp_q.push_back({(n == NBR - 1) ? 1'b1 : 1'b0, RW'(h), NW'(n)});
    bus.start = 1'b1;
    while (t < 400 && !(done_cyc >= 0 && t > done_cyc)) begin
      if (t > 0 && !hold_start) bus.start = 1'b0;
      if (rand_stall) cur_stall = ($urandom_range(0, 2) == 0);
      else            cur_stall = (t >= stall_lo && t <= stall_hi);
      cur_fv = (fv_q.size() > 0 && fv_q[0] == t);
      if (cur_fv) void'(fv_q.pop_front());
      bus.stall = cur_stall;
      bus.force_valid_in = cur_fv;
      @(negedge clk);
      exp_rden = issuing && !cur_stall;
      cur_last = 1'b0;
      check("rden", bus.rden, exp_rden);
      if (exp_rden && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("home_rdaddr", bus.home_rdaddr, e[RW+NW-1:NW]);
        check("neighbor_rdaddr", bus.neighbor_rdaddr, e[NW-1:0]);
        cur_last = e[PW-1];
      end
      check("r2_enable", bus.r2_enable, prev_rden);
      check("home_last", bus.home_last, prev_rden && prev_last);
      check("outstanding", bus.outstanding_dbg, out_m);
      check("outstanding_bound", bus.outstanding_dbg <= PL + 1, 1);
      exp_busy = (t >= 1) && (done_cyc < 0 || t <= done_cyc);
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, t == done_cyc);
`ifdef RL_SCHED_WATCHDOG_EN
      check("watchdog_err", bus.watchdog_err,
            (t == 0) ? wd_model : (drop_n > 0 && done_cyc >= 0 && t >= done_cyc));
`endif
      if (bus.done) done_seen++;
      // model update for the edge closing cycle t
      if (prev_rden) begin
        if (r2_n < N - drop_n) fv_q.push_back(t + PL);
        r2_n++;
      end
      if (cur_fv && out_m > 0) out_m--;
      if (exp_rden) begin
        out_m++;
        issued++;
        if (issued == N) issuing = 0;
      end
      if (cur_fv) begin
        retired++;
        if (retired == N - drop_n) done_cyc = (drop_n > 0) ? t + 2 * PL : t + 1;
      end
      if (drop_n > 0 && done_cyc >= 0 && t + 1 == done_cyc) out_m = 0;
      if (t == 0) issuing = 1;
      prev_rden = exp_rden;
      prev_last = cur_last;
      @(posedge clk);
      #1;
      t++;
    end
    bus.stall = 1'b0;
    bus.force_valid_in = 1'b0;
    check("run_completes", done_cyc >= 0 && t > done_cyc, 1);
    check("done_count", done_seen, 1);
    check("pairs_issued", issued, N);
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef RL_SCHED_WATCHDOG_EN
    wd_model = (drop_n > 0);
`endif
    run_len = done_cyc;
  endtask

  initial begin
    int len_plain, len_stall, len_tmp;
    bit found;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.force_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset values while rst is held
    check("rst_rden", bus.rden, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_r2_enable", bus.r2_enable, 0);
    check("rst_home_last", bus.home_last, 0);
    check("rst_home_addr", bus.home_rdaddr, 0);
    check("rst_nbr_addr", bus.neighbor_rdaddr, 0);
    check("rst_outstanding", bus.outstanding_dbg, 0);
    rst = 1'b0;

    // stray force_valid_in in IDLE
    bus.force_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.force_valid_in = 1'b0;
    @(negedge clk);
    check("stray_fv_outstanding", bus.outstanding_dbg, 0);
    check("stray_fv_busy", bus.busy, 0);
    @(posedge clk); #1;

    run_one(1000, -1, 1'b0, 1'b0, 0, len_plain);
    check("done_latency", len_plain, N + PL + 2);
    run_one(3, 6, 1'b0, 1'b0, 0, len_stall);
    check("stall_delay", len_stall - len_plain, 4);
    for (int k = 0; k < 3; k++) run_one(1000, -1, 1'b1, 1'b0, 0, len_tmp);

    // start held high: one run, then IDLE for a cycle, then a fresh run from (0,0)
    run_one(1000, -1, 1'b0, 1'b1, 0, len_tmp);
    @(negedge clk);
    check("held_idle_busy", bus.busy, 0);
    check("held_idle_rden", bus.rden, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("held_restart_rden", bus.rden, 1);
    check("held_restart_home", bus.home_rdaddr, 0);
    check("held_restart_nbr", bus.neighbor_rdaddr, 0);

    // async reset while pair (1,2) is being issued
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.rden && bus.home_rdaddr == 1 && bus.neighbor_rdaddr == 2) found = 1'b1;
    end
    check("reached_1_2", found, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_rden", bus.rden, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_r2_enable", bus.r2_enable, 0);
    check("arst_home_last", bus.home_last, 0);
    check("arst_home_addr", bus.home_rdaddr, 0);
    check("arst_nbr_addr", bus.neighbor_rdaddr, 0);
    check("arst_outstanding", bus.outstanding_dbg, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_done", bus.done, 0);
      check("post_rst_busy", bus.busy, 0);
      @(posedge clk); #1;
    end
    run_one(1000, -1, 1'b0, 1'b0, 0, len_tmp);
    check("restart_latency", len_tmp, N + PL + 2);

`ifdef RL_SCHED_WATCHDOG_EN
    run_one(1000, -1, 1'b0, 1'b0, 2, len_tmp);
    run_one(1000, -1, 1'b0, 1'b0, 0, len_tmp);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rl_pair_scheduler.md
Name: rl_pair_scheduler

Overview:
- Sequences one range-limited LJ force pipeline tile.
- Generates home/neighbor position-RAM read addresses and read enables, and drives r2_enable one cycle behind rden.
- Counts pairs in flight through the fixed-latency r2/force datapath.
- Asserts done only after the last pair's force has left the pipeline.
- Supports downstream back-pressure (stall) by pausing pair issue.

Parameters:
- REF_PARTICLE_NUM, 100, number of home (reference) particles.
- REF_RAM_ADDR_WIDTH, 7, home address width, ceil(log2(REF_PARTICLE_NUM)).
- NEIGHBOR_PARTICLE_NUM, 100, number of neighbor particles.
- NEIGHBOR_RAM_ADDR_WIDTH, 7, neighbor address width.
- PIPE_LATENCY, 31, cycles from r2_enable to force_valid_in for one pair.
- OUTSTANDING_WIDTH, 6, in-flight counter width; must hold PIPE_LATENCY+2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level or pulse; sampled only in IDLE.
- stall  in  1  high = do not issue a pair this cycle.
- force_valid_in  in  1  one pulse per pair completed by the force pipeline.
- home_rdaddr  out  REF_RAM_ADDR_WIDTH  home RAM read address.
- neighbor_rdaddr  out  NEIGHBOR_RAM_ADDR_WIDTH  neighbor RAM read address.
- rden  out  1  RAM read enable; high = a pair is issued this cycle.
- r2_enable  out  1  rden delayed 1 cycle, aligned with RAM q data.
- home_last  out  1  aligned with r2_enable; pair was neighbor NEIGHBOR_PARTICLE_NUM-1 of its home.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse at end of run.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; address counters 0; outstanding 0.
  - r2_enable=0, home_last=0, done=0; rden=0 and busy=0 (decoded from IDLE).
  - Reset mid-run abandons the run immediately. No done is produced. Pairs already in the datapath are not tracked after reset.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - addresses held at 0.
  - start=1 -> ISSUE on the next edge.
  - start is ignored in all other states.
- ISSUE:
  - rden = ~stall (combinational from state and stall); no other output depends combinationally on inputs.
  - Each edge with rden=1 advances the counters. If neighbor == NEIGHBOR_PARTICLE_NUM-1: neighbor -> 0, home +1. Otherwise neighbor +1.
  - With stall=1, addresses hold and no pair is counted.
  - Edge with rden=1 at home=REF-1, neighbor=NBR-1: go to DRAIN, counters -> 0.
- Issue order: home-major, neighbor-minor. Exactly REF_PARTICLE_NUM*NEIGHBOR_PARTICLE_NUM pairs per run.
- Registered outputs on every edge:
  - r2_enable <= rden.
  - home_last <= rden & (neighbor == NEIGHBOR_PARTICLE_NUM-1).
- Outstanding counter:
  - Increments on an edge with rden=1; decrements on an edge with force_valid_in=1.
  - Both in the same cycle: value unchanged.
  - force_valid_in while outstanding=0 is ignored (saturate at 0).
- DRAIN:
  - rden=0.
  - Leaves for DONE on the edge where next outstanding == 0, i.e. outstanding==1 and force_valid_in=1, or outstanding already 0.
- DONE: done=1 for exactly one cycle, then IDLE. A start asserted during DONE is ignored.
- Timing with no stalls:
  - first rden: 1 cycle after start is sampled.
  - last rden: N-1 cycles after the first rden, where N = REF*NBR.
  - done: the cycle after the final force_valid_in.

Optional Feature:
- Macro: RL_SCHED_WATCHDOG_EN.
- When defined:
  - adds output port watchdog_err (1 bit, reset 0).
  - In DRAIN, a counter clears on each force_valid_in and otherwise increments.
  - If it reaches 2*PIPE_LATENCY, the block sets watchdog_err=1, clears outstanding and goes to DONE (done pulses normally).
  - watchdog_err stays high until the next accepted start or reset.
- When undefined: the port and counter are absent, and DRAIN waits indefinitely for outstanding==0.

Test Plan:
- REF=3, NBR=4, PIPE_LATENCY=5, model returns force_valid_in 5 cycles after r2_enable, start pulse:
  - 12 consecutive rden cycles.
  - address sequence (0,0),(0,1),(0,2),(0,3),(1,0)…(2,3).
  - home_last high on the 4th, 8th and 12th r2_enable.
  - done 1 cycle after the 12th force_valid_in.
- Same setup, stall high for cycles 3-6 of ISSUE:
  - rden low and addresses frozen during the stall.
  - still exactly 12 pairs with no duplicates or skips; done is delayed by 4 cycles.
- start held high throughout a run:
  - only one run occurs.
  - after done, the block re-enters ISSUE from (0,0) the cycle after IDLE.
- Simultaneous issue and force_valid_in:
  - outstanding is unchanged on those cycles.
  - outstanding never exceeds PIPE_LATENCY+1.
  - a stray force_valid_in in IDLE leaves it at 0.
- rst asserted asynchronously mid-ISSUE at address (1,2):
  - all outputs go to reset values immediately, with no done pulse.
  - a new start restarts from (0,0).
- With RL_SCHED_WATCHDOG_EN defined, drop the last 2 force_valid_in pulses:
  - watchdog_err=1 and done pulses 10 cycles after the last received pulse.
  - watchdog_err clears on the next start.
